// File: rtl/dmem_responder.sv
// Word-wide data memory behind a load/store handshake; done pulses WAIT+1 cycles after accept.
// Backpressure: ready is low while a request is in flight and strobes seen then are dropped, not queued.
module dmem_responder #(
    parameter int DATA_W = 32,
    parameter int AW     = 6,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_wr_q, is_wr_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic accept;
    logic resp_ok;
    logic unused_addr_hi;

    // Address bits above the word index alias onto the same word.
    assign unused_addr_hi = ^addr[31:AW+2];

    assign accept  = (state_q == S_IDLE) && (MemRead || MemWrite);
    assign resp_ok = (state_q == S_RESP) && !bad_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (WAIT == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_RESP);
        err   = (state_q == S_RESP) && bad_q;
        rdata = rdata_d;
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        is_wr_d = is_wr_q;
        bad_d   = bad_q;
        if (accept) begin
            cnt_d   = WAIT_CNT;
            idx_d   = addr[AW+1:2];
            wdat_d  = wdata;
            is_wr_d = MemWrite;
            bad_d   = (MemRead && MemWrite) || (addr[1:0] != 2'b00);
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        rdata_d = rdata_q;
        if (resp_ok && is_wr_q) begin
            mem_d[idx_q] = wdat_q;
        end
        // Load data is visible combinationally in the done cycle and held from then on.
        if (resp_ok && !is_wr_q) begin
            rdata_d = mem_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
            bad_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
            bad_q   <= bad_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle/multi-cycle RISC-V datapath.
- Consumes the MemRead/MemWrite strobes the control unit asserts for load/store opcodes.
- Performs word accesses against an internal register-file memory after a programmable number of wait states.
- Signals completion with a one-cycle done pulse so the datapath can stall on ready.

Parameters:
- DATA_W, 32, data word width in bits.
- AW, 6, word-address width; memory depth is 2^AW words.
- WAIT, 2, wait states inserted between request accept and access (legal 0..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- MemRead  input  1  load request strobe.
- MemWrite  input  1  store request strobe.
- addr  input  32  byte address; word index = addr[AW+1:2]; bits above AW+1 ignored (wrap).
- wdata  input  DATA_W  store data.
- ready  output  1  high when idle and able to accept a request.
- done  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  load result; valid in the done cycle, held until next successful load completes.
- err  output  1  valid with done; request was rejected.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, done=0, err=0, rdata=0, all memory words=0. ready=1 once in IDLE, including during reset.
- Reset mid-operation aborts the request. A pending store is not committed, and no done is issued.
- States:
  - IDLE: ready=1.
  - WAIT: ready=0, counter decrements each cycle.
  - RESP: ready=0, access performed, done=1.
- Accept condition: rising edge with state IDLE and (MemRead|MemWrite)=1. On accept, capture addr, wdata, op and the error condition, and load counter=WAIT.
- Transitions:
  - IDLE to WAIT on accept when WAIT>0.
  - IDLE to RESP on accept when WAIT=0.
  - WAIT to RESP when counter reaches 1 on that edge, i.e. exactly WAIT cycles in WAIT.
  - RESP to IDLE unconditionally.
- Latency: done is asserted exactly WAIT+1 cycles after the accept edge. Back-to-back throughput is one request per WAIT+2 cycles.
- RESP, store: mem[word]<=captured wdata at the RESP-exit edge; rdata unchanged.
- RESP, load: rdata driven with mem[word] during the RESP cycle, registered/held afterwards.
- Error cases: err=1 with done, and no memory access or rdata update. They are:
  - MemRead and MemWrite both 1 at accept.
  - Captured addr[1:0] != 2'b00 (misaligned).
- err=0 whenever done=0.
- Requests presented while ready=0 are ignored, not queued. The datapath must hold its strobe until it sees ready.
- Inputs changing after accept have no effect on the in-flight access.
- A load from the same word immediately after a store returns the new data; the store commits before the next accept.
- Word wrap: addr beyond 4*2^AW aliases onto addr[AW+1:2]; this is not an error.

Test Plan:
1. Reset then store: WAIT=2, rst low 3 cycles, then MemWrite=1, addr=0x10, wdata=0xDEADBEEF for one cycle -> ready low 3 cycles, done=1/err=0 on 3rd cycle after accept, ready high next cycle.
2. Load-after-store: after scenario 1, MemRead=1, addr=0x10 -> done 3 cycles later with rdata=0xDEADBEEF, rdata held after done drops. Load from addr=0x14 -> rdata=0x00000000.
3. Zero-wait: WAIT=0, store 0x12345678 to 0x04, then load 0x04 -> each done exactly 1 cycle after accept, rdata=0x12345678, accepts every 2 cycles.
4. Errors:
   - MemRead=MemWrite=1, addr=0x08 -> done=1, err=1, mem[2] unchanged.
   - MemWrite=1, addr=0x0A -> done=1, err=1, no write; a subsequent load of 0x08 returns its prior value with err=0.
5. Mid-operation reset: WAIT=4, store 0xCAFEF00D to 0x20, assert rst during WAIT -> no done, ready=1 immediately. A load of 0x20 after release returns 0x00000000.
6. Wrap and ignore-while-busy: store 0xA5A5A5A5 to 0x100 (AW=6) -> a load of 0x000 returns 0xA5A5A5A5. A second MemWrite pulse during WAIT is ignored, and only one done is seen.
